// File: rtl/link_rx.sv
// link_rx: receive stage of the inter-board link.
// Raw peer lines are synchronised, glitch-filtered and turned into clean
// ready levels plus a held throw event (valid/ack) with captured power.

// Stability filter: output follows the synchronised input once the input
// has held one value, different from the output, for STABLE_CYCLES edges.
module link_rx_filter #(
    parameter int W             = 1,
    parameter int STABLE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);

    logic [W-1:0]  q_r;
    logic [W-1:0]  cand_r;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] run_s;

    // Length of the current run of identical samples that differ from the output
    always_comb begin
        run_s = '0;
        if (d == q_r) begin
            run_s = '0;
        end else if ((d == cand_r) && (cnt_r != '0)) begin
            run_s = cnt_r + CW'(1'b1);
        end else begin
            run_s = CW'(1'b1);
        end
    end

    // Run counter, candidate value and filtered output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r    <= '0;
            cand_r <= '0;
            cnt_r  <= '0;
        end else if (d == q_r) begin
            cnt_r <= '0;
        end else if (run_s == CW'(STABLE_CYCLES)) begin
            q_r   <= d;
            cnt_r <= '0;
        end else begin
            cnt_r  <= run_s;
            cand_r <= d;
        end
    end

    assign q = q_r;
endmodule

module link_rx #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_player1_ready,
    input  logic       in_player2_ready,
    input  logic [4:0] in_power,
    input  logic       in_throw_flag,
    input  logic       throw_ack,
    output logic       player1_ready,
    output logic       player2_ready,
    output logic       throw_valid,
    output logic [4:0] throw_power,
    output logic       overrun
);
    localparam int SETTLE = SYNC_STAGES + STABLE_CYCLES;
    localparam int SW     = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        ARMED    = 2'd1,
        PENDING  = 2'd2,
        HOLD     = 2'd3
    } state_t;

    logic [7:0]                   raw_s;
    logic [SYNC_STAGES-1:0][7:0]  sync_r;
    logic [7:0]                   sync_s;
    logic                         p1_f_s;
    logic                         p2_f_s;
    logic                         throw_f_s;
    logic [4:0]                   power_f_s;
    logic                         throw_f_d_r;
    logic                         rise_s;
    logic [SW-1:0]                settle_cnt_r;
    logic                         settle_done_s;
    state_t                       state_r;
    state_t                       state_nxt_s;
    logic                         valid_r;
    logic [4:0]                   power_r;
    logic                         overrun_r;
    logic                         valid_nxt_s;
    logic [4:0]                   power_nxt_s;
    logic                         overrun_nxt_s;

    assign raw_s  = {in_power, in_throw_flag, in_player2_ready, in_player1_ready};
    assign sync_s = sync_r[SYNC_STAGES-1];

    // Per-line synchroniser chains for all eight raw peer lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], raw_s};
        end
    end

    link_rx_filter #(.W(1), .STABLE_CYCLES(STABLE_CYCLES)) u_f_p1 (
        .clk(clk), .rst(rst), .d(sync_s[0]), .q(p1_f_s)
    );
    link_rx_filter #(.W(1), .STABLE_CYCLES(STABLE_CYCLES)) u_f_p2 (
        .clk(clk), .rst(rst), .d(sync_s[1]), .q(p2_f_s)
    );
    link_rx_filter #(.W(1), .STABLE_CYCLES(STABLE_CYCLES)) u_f_throw (
        .clk(clk), .rst(rst), .d(sync_s[2]), .q(throw_f_s)
    );
    // Power is filtered as one bus so a change on any bit restarts the count
    link_rx_filter #(.W(5), .STABLE_CYCLES(STABLE_CYCLES)) u_f_power (
        .clk(clk), .rst(rst), .d(sync_s[7:3]), .q(power_f_s)
    );

    assign rise_s        = throw_f_s & ~throw_f_d_r;
    assign settle_done_s = (settle_cnt_r == SW'(SETTLE));

    // Delayed throw flag for edge detect and post-reset settle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            throw_f_d_r  <= 1'b0;
            settle_cnt_r <= '0;
        end else begin
            throw_f_d_r <= throw_f_s;
            if (!settle_done_s) begin
                settle_cnt_r <= settle_cnt_r + SW'(1'b1);
            end else begin
                settle_cnt_r <= settle_cnt_r;
            end
        end
    end

    // Throw FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= WAIT_LOW;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Throw FSM next state; a flag already high after reset must drop first
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            WAIT_LOW: begin
                if (settle_done_s && !throw_f_s) begin
                    state_nxt_s = ARMED;
                end else begin
                    state_nxt_s = WAIT_LOW;
                end
            end
            ARMED: begin
                if (rise_s) begin
                    state_nxt_s = PENDING;
                end else begin
                    state_nxt_s = ARMED;
                end
            end
            PENDING: begin
                if (throw_ack && !rise_s) begin
                    state_nxt_s = throw_f_s ? HOLD : ARMED;
                end else begin
                    state_nxt_s = PENDING;
                end
            end
            HOLD: begin
                if (!throw_f_s) begin
                    state_nxt_s = ARMED;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: state_nxt_s = WAIT_LOW;
        endcase
    end

    // Next values of the registered throw outputs
    always_comb begin
        valid_nxt_s   = valid_r;
        power_nxt_s   = power_r;
        overrun_nxt_s = overrun_r;
        case (state_r)
            ARMED: begin
                if (rise_s) begin
                    valid_nxt_s = 1'b1;
                    power_nxt_s = power_f_s;
                end else begin
                    valid_nxt_s = valid_r;
                end
            end
            PENDING: begin
                if (throw_ack && rise_s) begin
                    power_nxt_s = power_f_s;
                end else if (throw_ack) begin
                    valid_nxt_s = 1'b0;
                end else if (rise_s) begin
                    overrun_nxt_s = 1'b1;
                end else begin
                    valid_nxt_s = valid_r;
                end
            end
            default: begin
                valid_nxt_s = valid_r;
            end
        endcase
    end

    // Registered throw outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r   <= 1'b0;
            power_r   <= 5'd0;
            overrun_r <= 1'b0;
        end else begin
            valid_r   <= valid_nxt_s;
            power_r   <= power_nxt_s;
            overrun_r <= overrun_nxt_s;
        end
    end

    assign player1_ready = p1_f_s;
    assign player2_ready = p2_f_s;
    assign throw_valid   = valid_r;
    assign throw_power   = power_r;
    assign overrun       = overrun_r;
endmodule
